led_flow_gen: RTL
=================

Name: led_flow_gen

Overview:
- Parametrised successor LED sequencer for the board demo path. It drives an LED_N-bit bank with one of four patterns: rotate, ping-pong, bar fill/drain, or blink.
- A selectable step period, a run/pause toggle from a synchronised push-button, and a one-cycle step strobe are provided for downstream blocks such as the seven-segment display or a buzzer.
- The block sits directly behind the board switch/button inputs and has a single clock domain.

Parameters:
- LED_N, 8, number of LEDs; legal range 2..32.
- TICK_BASE, 1000, base step period in clk cycles; speed multipliers apply to this value.
- CNT_W, 25, period counter width; must hold 200*TICK_BASE-1.
- DEB_CYC, 16, stable-cycle count for button debounce; used only with DEBOUNCE_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- button  input  1  asynchronous push-button, active-high; a rising edge toggles run/pause.
- freq_set  input  2  step period select: 00 = 1x, 01 = 10x, 10 = 50x, 11 = 200x TICK_BASE.
- dir_set  input  1  direction for rotate mode: 1 = toward MSB, 0 = toward LSB.
- mode  input  2  pattern select: 00 rotate, 01 ping-pong, 10 bar, 11 blink.
- led  output  LED_N  LED drive, registered.
- running  output  1  1 = sequencer advancing, registered.
- step  output  1  one-cycle pulse on each pattern advance, registered.

Behaviour:
- Reset (rst_n low at a clk edge):
  - led = 1 (bit0 only), running = 0, step = 0.
  - Period counter = 0, synchroniser and edge flops = 0, mode_q = mode, ping-pong direction = up, bar level = 1.
- Button path:
  - Two-flop synchroniser, then an edge register. A rising edge is synced & ~prev.
  - running toggles on the 3rd rising clk edge after button is first sampled high.
  - Holding button high gives exactly one toggle.
- Period:
  - P = mult*TICK_BASE.
  - While running = 1, the counter counts 0..P-1. When counter == P-1, the counter returns to 0 and a step event fires on that edge: the pattern updates and step = 1 for one cycle.
  - Counter width arithmetic is unsigned, with no overflow for legal parameters.
- freq_set change mid-period:
  - The new P applies immediately.
  - If counter >= new P-1, the step fires on the next edge and the counter clears.
- Pause (running = 0): counter, led, and pattern state hold; step = 0. Resume continues from the held count.
- Mode change (mode != mode_q):
  - On that edge, mode_q updates, the counter clears, and led loads the initial pattern of the new mode. No step pulse is issued.
  - This happens even when paused.
- Initial patterns and step rules:
  - Rotate: initial 1. Step rotates left by 1 if dir_set = 1, otherwise right by 1, with wrap (MSB->bit0 or bit0->MSB). dir_set is sampled at the step edge.
  - Ping-pong: initial 1, direction up. Step shifts one-hot toward MSB while up. When led == MSB, direction flips and that step moves to bit LSN-2. Symmetric at bit0. Ends are never held for two periods. dir_set is ignored.
  - Bar: initial level 1 (led = 0..01). Level grows by 1 per step up to LED_N (all ones), then shrinks by 1 down to 1, then grows again. led = (1<<level)-1.
  - Blink: initial all zeros. Each step inverts all bits.
- Reset mid-period or mid-pattern: reset has full priority over step and mode change.
- Button toggle and step on the same edge: the step completes using the pre-toggle running value.

Optional Feature:
- Macro LED_FLOW_DEBOUNCE_EN.
- Defined: after the synchroniser, a counter requires the synced level to differ from the debounced level for DEB_CYC consecutive cycles before the debounced level changes. Edge detection uses the debounced level, so running toggles DEB_CYC+3 edges after a clean press. Glitches shorter than DEB_CYC cycles are ignored.
- Undefined: there is no debounce counter; latency is 3 edges and every synchronised rising edge toggles running.

Test Plan:
- Sim settings: LED_N = 8, TICK_BASE = 4.
- Reset, then press button: running = 1 at the 3rd edge. With freq_set = 00, mode = 00, dir_set = 1, led goes 01 -> 02 -> 04 every 4 cycles. step pulses once per change. After 8 steps led = 01 (wrap).
- mode = 01, running: led sequence 01, 02, ..., 80, 40, ..., 01, 02. Each value lasts 4 cycles and 80 never repeats consecutively.
- mode = 10: led sequence 01, 03, 07, ..., FF, 7F, ..., 01, 03.
- mode = 11 with freq_set = 01: led toggles 00 <-> FF every 40 cycles. Switching freq_set to 00 when counter = 20 gives a step on the next edge.
- Pause mid-period at counter = 2: led and counter hold for 100 cycles. Resume gives the next step 2 cycles after running rises. A mode change while paused loads the initial pattern with step = 0.
- With LED_FLOW_DEBOUNCE_EN and DEB_CYC = 16: a 10-cycle button glitch gives no toggle. A 30-cycle press toggles running exactly once, 19 edges after the press. Asserting rst_n = 0 mid-run restores led = 01 and running = 0 on the next edge.

Source files
------------

// File: rtl/led_flow_gen.sv
// LED pattern sequencer: rotate / ping-pong / bar / blink, button run-pause toggle, step strobe.
// Define LED_FLOW_DEBOUNCE_EN to debounce the synchronised button for DEB_CYC cycles.
module led_flow_gen #(
    parameter int unsigned LED_N     = 8,
    parameter int unsigned TICK_BASE = 1000,
    parameter int unsigned CNT_W     = 25,
    parameter int unsigned DEB_CYC   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button,
    input  logic [1:0]       freq_set,
    input  logic             dir_set,
    input  logic [1:0]       mode,
    output logic [LED_N-1:0] led,
    output logic             running,
    output logic             step
);

    localparam int unsigned LVL_W = $clog2(LED_N + 1);
    localparam logic [CNT_W-1:0] PM1_X1   = CNT_W'(TICK_BASE - 1);
    localparam logic [CNT_W-1:0] PM1_X10  = CNT_W'(10 * TICK_BASE - 1);
    localparam logic [CNT_W-1:0] PM1_X50  = CNT_W'(50 * TICK_BASE - 1);
    localparam logic [CNT_W-1:0] PM1_X200 = CNT_W'(200 * TICK_BASE - 1);

    localparam logic [1:0] MODE_ROT   = 2'b00;
    localparam logic [1:0] MODE_PP    = 2'b01;
    localparam logic [1:0] MODE_BAR   = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    if (LED_N < 2 || LED_N > 32 || DEB_CYC < 1 || CNT_W < $clog2(200 * TICK_BASE)) begin : g_param_check
        $error("led_flow_gen: illegal parameter set");
    end

    typedef enum logic {DIR_UP, DIR_DN} dir_t;

    logic sync1, sync2, prev, btn_lvl, btn_rise;

    // Button synchroniser and edge register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            prev  <= btn_lvl;
        end
    end

`ifdef LED_FLOW_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_lvl;

    // Level only follows the synced input after DEB_CYC consecutive differing cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            deb_lvl <= 1'b0;
        end else if (sync2 == deb_lvl) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
            deb_cnt <= '0;
            deb_lvl <= sync2;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end
    assign btn_lvl = deb_lvl;
`else
    assign btn_lvl = sync2;
`endif

    assign btn_rise = btn_lvl & ~prev;

    logic [CNT_W-1:0] cnt_q, cnt_d, period_m1;
    logic [LED_N-1:0] led_d;
    logic             running_d, step_d;
    logic [1:0]       mode_q, mode_d;
    dir_t             dir_q, dir_d;
    logic [LVL_W-1:0] level_q, level_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            led     <= LED_N'(1);
            running <= 1'b0;
            step    <= 1'b0;
            mode_q  <= mode;
            dir_q   <= DIR_UP;
            level_q <= LVL_W'(1);
        end else begin
            cnt_q   <= cnt_d;
            led     <= led_d;
            running <= running_d;
            step    <= step_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        led_d     = led;
        running_d = running ^ btn_rise;
        step_d    = 1'b0;
        mode_d    = mode_q;
        dir_d     = dir_q;
        level_d   = level_q;

        unique case (freq_set)
            2'b00:   period_m1 = PM1_X1;
            2'b01:   period_m1 = PM1_X10;
            2'b10:   period_m1 = PM1_X50;
            default: period_m1 = PM1_X200;
        endcase

        // Mode change reloads the pattern and wins over a pending step
        if (mode != mode_q) begin
            mode_d  = mode;
            cnt_d   = '0;
            dir_d   = DIR_UP;
            level_d = LVL_W'(1);
            led_d   = (mode == MODE_BLINK) ? '0 : LED_N'(1);
        end else if (running) begin
            if (cnt_q >= period_m1) begin
                cnt_d  = '0;
                step_d = 1'b1;
                unique case (mode_q)
                    MODE_ROT: begin
                        if (dir_set) led_d = {led[LED_N-2:0], led[LED_N-1]};
                        else         led_d = {led[0], led[LED_N-1:1]};
                    end
                    MODE_PP: begin
                        if (dir_q == DIR_UP) begin
                            if (led[LED_N-1]) begin
                                dir_d = DIR_DN;
                                led_d = led >> 1;
                            end else begin
                                led_d = led << 1;
                            end
                        end else begin
                            if (led[0]) begin
                                dir_d = DIR_UP;
                                led_d = led << 1;
                            end else begin
                                led_d = led >> 1;
                            end
                        end
                    end
                    MODE_BAR: begin
                        if (dir_q == DIR_UP) begin
                            if (level_q == LVL_W'(LED_N)) begin
                                dir_d   = DIR_DN;
                                level_d = level_q - LVL_W'(1);
                            end else begin
                                level_d = level_q + LVL_W'(1);
                            end
                        end else begin
                            if (level_q == LVL_W'(1)) begin
                                dir_d   = DIR_UP;
                                level_d = level_q + LVL_W'(1);
                            end else begin
                                level_d = level_q - LVL_W'(1);
                            end
                        end
                        led_d = ~({LED_N{1'b1}} << level_d);
                    end
                    default: led_d = ~led;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
